ccff_chain_programmer: RTL and testbench

- Drives the configuration flip-flop chain of a routing tile, such as a connection-block mux memory chain, from its ccff_head end.
- Accepts bitstream words on a valid/ready stream and serializes them MSB-first into the chain, one bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits.
- At the same time it collects the bits leaving the chain's ccff_tail end and repacks them into readback words, giving configuration readback and chain-integrity checking.

---
 rtl/ccff_chain_programmer.sv | 184 ++++++++++++++++++
 tb/tb_ccff_chain_programmer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_programmer.sv
// Configuration-chain programmer: serializes bitstream words MSB-first into a
// ccff chain from its head end while repacking the bits that fall out of the
// tail into readback words (first tail bit in the MSB).
//
// Handshake: a word on in_data is transferred on a rising prog_clk edge where
// in_valid and in_ready are both high; in_valid may rise or fall freely while
// in_ready is low, and rb_valid is a one-cycle strobe with no backpressure.
module ccff_chain_programmer #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic [2:0]        dbg_state
);

  localparam int RW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] W_C    = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [RW-1:0]    W_RW   = RW'(WORD_W);
  localparam logic [RW-1:0]    ONE_RW = RW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [RW-1:0]     fill_q, fill_d;
  logic [WORD_W-1:0] rb_sr_q, rb_sr_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_ready_q, in_ready_d;

  logic [CNT_W-1:0]  left_c;
  logic [CNT_W-1:0]  total_inc;
  logic              word_full;

  // State and datapath registers; reset aborts any pass in flight.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      total_q    <= '0;
      rem_q      <= '0;
      fill_q     <= '0;
      rb_sr_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      total_q    <= total_d;
      rem_q      <= rem_d;
      fill_q     <= fill_d;
      rb_sr_q    <= rb_sr_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic; every output is decoded from the next state so that the
  // chain-facing signals come straight from flops.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    total_d    = total_q;
    rem_d      = rem_q;
    fill_d     = fill_q;
    rb_sr_d    = rb_sr_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    head_d     = head_q;
    left_c     = LEN_C - total_q;
    total_inc  = total_q + ONE_C;
    word_full  = (fill_q == (W_RW - ONE_RW));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          total_d = '0;
          fill_d  = '0;
          rb_sr_d = '0;
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          word_d  = in_data;
          head_d  = in_data[WORD_W-1];
          // The last word of a pass may only carry the leftover bits.
          rem_d   = (left_c >= W_C) ? W_RW : left_c[RW-1:0];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        word_d  = word_q << 1;
        total_d = total_inc;
        rem_d   = rem_q - ONE_RW;
        rb_sr_d = {rb_sr_q[WORD_W-2:0], ccff_tail};
        if (word_full) begin
          rb_data_d  = {rb_sr_q[WORD_W-2:0], ccff_tail};
          rb_valid_d = 1'b1;
          fill_d     = '0;
        end else begin
          fill_d = fill_q + ONE_RW;
        end
        if (rem_q == ONE_RW) begin
          // head keeps the last shifted bit while the chain is idle.
          if (total_inc == LEN_C) begin
            state_d = word_full ? ST_DONE : ST_FLUSH;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          head_d = word_q[WORD_W-2];
        end
      end
      ST_FLUSH: begin
        // Left-align the leftover tail bits, zero below them.
        rb_data_d  = rb_sr_q << (W_RW - fill_q);
        rb_valid_d = 1'b1;
        rb_sr_d    = '0;
        fill_d     = '0;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    shift_en_d = (state_d == ST_SHIFT);
    in_ready_d = (state_d == ST_FETCH);
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_SHIFT) ||
                 (state_d == ST_FLUSH);
    done_d     = (state_d == ST_DONE);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign in_ready      = in_ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign rb_data       = rb_data_q;
  assign rb_valid      = rb_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Bench for ccff_chain_programmer: a 48-bit and a 20-bit instance, each
// feeding a behavioural flip-flop chain whose tail loops back for readback.
module tb_ccff_chain_programmer;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_rb;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [7:0] in_data = '0;
  logic start48 = 1'b0, in_valid48 = 1'b0;
  logic start20 = 1'b0, in_valid20 = 1'b0;
  logic busy48, done48, in_ready48, head48, shift48, tail48, rb_valid48;
  logic busy20, done20, in_ready20, head20, shift20, tail20, rb_valid20;
  logic [7:0] rb_data48, rb_data20;
  logic [2:0] dbg48, dbg20;

  logic [47:0] chain48 = '0;
  logic [19:0] chain20 = '0;
  assign tail48 = chain48[47];
  assign tail20 = chain20[19];

  // Behavioural configuration chains.
  always @(posedge prog_clk) begin
    if (shift48) chain48 <= {chain48[46:0], head48};
    if (shift20) chain20 <= {chain20[18:0], head20};
  end

  ccff_chain_programmer #(.CHAIN_LEN(48), .WORD_W(8), .CNT_W(16)) u_dut48 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start48), .busy(busy48),
    .done(done48), .in_data(in_data), .in_valid(in_valid48),
    .in_ready(in_ready48), .ccff_head(head48), .ccff_shift_en(shift48),
    .ccff_tail(tail48), .rb_data(rb_data48), .rb_valid(rb_valid48),
    .dbg_state(dbg48)
  );

  ccff_chain_programmer #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) u_dut20 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start20), .busy(busy20),
    .done(done20), .in_data(in_data), .in_valid(in_valid20),
    .in_ready(in_ready20), .ccff_head(head20), .ccff_shift_en(shift20),
    .ccff_tail(tail20), .rb_data(rb_data20), .rb_valid(rb_valid20),
    .dbg_state(dbg20)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp48_q[$];
  logic [7:0] exp20_q[$];
  logic hexp48_q[$];
  logic hexp20_q[$];
  int shift_cnt[2] = '{0, 0};
  int done_cnt[2]  = '{0, 0};
  int done_cyc[2]  = '{0, 0};
  int acc_cnt[2]   = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? in_ready20 : in_ready48;
  endfunction
  function automatic logic sh(input int sel);
    return (sel == 1) ? shift20 : shift48;
  endfunction
  function automatic logic hd(input int sel);
    return (sel == 1) ? head20 : head48;
  endfunction
  function automatic logic bz(input int sel);
    return (sel == 1) ? busy20 : busy48;
  endfunction

  task automatic mon(input int sel);
    logic e;
    logic [7:0] ew;
    if (sh(sel)) begin
      shift_cnt[sel]++;
      if ((sel == 1) ? (hexp20_q.size() == 0) : (hexp48_q.size() == 0)) begin
        checks++; failures++;
        $display("FAIL head_extra_shift dut=%0d actual=shift required=none", sel);
      end else begin
        e = (sel == 1) ? hexp20_q.pop_front() : hexp48_q.pop_front();
        chk($sformatf("head_bit_dut%0d", sel), 32'(hd(sel)), 32'(e));
      end
    end
    if ((sel == 1) ? rb_valid20 : rb_valid48) begin
      if ((sel == 1) ? (exp20_q.size() == 0) : (exp48_q.size() == 0)) begin
        checks++; failures++;
        $display("FAIL rb_extra dut=%0d actual=%0h required=none", sel,
                 (sel == 1) ? rb_data20 : rb_data48);
      end else begin
        ew = (sel == 1) ? exp20_q.pop_front() : exp48_q.pop_front();
        chk($sformatf("rb_data_dut%0d", sel), 32'((sel == 1) ? rb_data20 : rb_data48), 32'(ew));
      end
    end
    if ((sel == 1) ? done20 : done48) begin
      done_cnt[sel]++;
      done_cyc[sel] = cyc;
    end
  endtask

  always @(negedge prog_clk) begin
    mon(0);
    mon(1);
  end

  always @(posedge prog_clk) begin
    if (in_valid48 && in_ready48) acc_cnt[0]++;
    if (in_valid20 && in_ready20) acc_cnt[1]++;
  end

  // ---------------- drivers ----------------
  logic [7:0] wbuf[6];
  logic [7:0] ebuf[6];
  vec_t tbl[24];

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) in_valid20 = v; else in_valid48 = v;
  endtask
  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start20 = v; else start48 = v;
  endtask

  // Hold the word with in_valid high until it is taken, then log the bits
  // expected on ccff_head for it.
  task automatic present_word(input int sel, input logic [7:0] w, input int nb, output bit ok);
    int t;
    in_data = w;
    set_valid(sel, 1'b1);
    t = 0;
    while (!rdy(sel) && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    if (!rdy(sel)) begin
      checks++; failures++;
      $display("FAIL word_accept_timeout dut=%0d actual=no_ready required=ready", sel);
      ok = 1'b0;
      return;
    end
    for (int b = 7; b >= 8 - nb; b--) begin
      if (sel == 1) hexp20_q.push_back(w[b]); else hexp48_q.push_back(w[b]);
    end
    @(negedge prog_clk);
    ok = 1'b1;
  endtask

  task automatic run_pass(input int sel, input int n, input int len, input bit stall,
                          input bit poke, input int exp_cyc);
    int db, sb, ab, t0, t, nb;
    bit ok;
    db = done_cnt[sel];
    sb = shift_cnt[sel];
    ab = acc_cnt[sel];
    for (int k = 0; k < n; k++) begin
      if (sel == 1) exp20_q.push_back(ebuf[k]); else exp48_q.push_back(ebuf[k]);
    end
    @(negedge prog_clk);
    set_start(sel, 1'b1);
    t0 = cyc;
    @(negedge prog_clk);
    set_start(sel, 1'b0);
    chk("busy_after_start", 32'(bz(sel)), 32'd1);
    for (int k = 0; k < n; k++) begin
      nb = (len - 8 * k >= 8) ? 8 : len - 8 * k;
      if (stall && k == 1) begin
        set_valid(sel, 1'b0);
        t = 0;
        while (!rdy(sel) && t < 200) begin
          @(negedge prog_clk);
          t++;
        end
        for (int i = 0; i < 5; i++) begin
          chk("stall_in_ready", 32'(rdy(sel)), 32'd1);
          chk("stall_shift_en", 32'(sh(sel)), 32'd0);
          chk("stall_head_held", 32'(hd(sel)), 32'(wbuf[0][0]));
          @(negedge prog_clk);
        end
      end
      present_word(sel, wbuf[k], nb, ok);
      if (!ok) break;
      if (poke && k == 2) begin
        set_start(sel, 1'b1);
        @(negedge prog_clk);
        set_start(sel, 1'b0);
      end
    end
    set_valid(sel, 1'b0);
    t = 0;
    while (done_cnt[sel] == db && t < 400) begin
      @(negedge prog_clk);
      t++;
    end
    chk("pass_cycles", 32'(done_cyc[sel] - t0), 32'(exp_cyc));
    repeat (6) @(negedge prog_clk);
    chk("done_pulses", 32'(done_cnt[sel] - db), 32'd1);
    chk("shift_count", 32'(shift_cnt[sel] - sb), 32'(len));
    chk("words_accepted", 32'(acc_cnt[sel] - ab), 32'(n));
    chk("rb_pending", 32'((sel == 1) ? exp20_q.size() : exp48_q.size()), 32'd0);
    chk("head_pending", 32'((sel == 1) ? hexp20_q.size() : hexp48_q.size()), 32'd0);
    chk("busy_after_done", 32'(bz(sel)), 32'd0);
  endtask

  task automatic load(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      wbuf[k] = tbl[base + k].din;
      ebuf[k] = tbl[base + k].exp_rb;
    end
  endtask

  // Expected readback from the current physical chain contents.
  task automatic load_chain_exp();
    for (int k = 0; k < 6; k++) ebuf[k] = chain48[47 - 8 * k -: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy48), 32'd0);
    chk({tag, "_done"}, 32'(done48), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready48), 32'd0);
    chk({tag, "_head"}, 32'(head48), 32'd0);
    chk({tag, "_shift_en"}, 32'(shift48), 32'd0);
    chk({tag, "_rb_valid"}, 32'(rb_valid48), 32'd0);
    chk({tag, "_rb_data"}, 32'(rb_data48), 32'd0);
    chk({tag, "_state"}, 32'(dbg48), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sb, db;
    bit ok;
    tbl = '{
      '{8'hA5, 8'h00}, '{8'h3C, 8'h00}, '{8'hFF, 8'h00},
      '{8'h00, 8'h00}, '{8'h81, 8'h00}, '{8'h7E, 8'h00},
      '{8'h11, 8'hA5}, '{8'h22, 8'h3C}, '{8'h33, 8'hFF},
      '{8'h44, 8'h00}, '{8'h55, 8'h81}, '{8'h66, 8'h7E},
      '{8'h5A, 8'h11}, '{8'hC3, 8'h22}, '{8'h96, 8'h33},
      '{8'h0F, 8'h44}, '{8'hF0, 8'h55}, '{8'h69, 8'h66},
      '{8'hF0, 8'h00}, '{8'h0F, 8'h00}, '{8'hDB, 8'h00},
      '{8'h12, 8'hF0}, '{8'h34, 8'h0F}, '{8'h56, 8'hD0}
    };

    #1;
    check_reset_outputs("reset");
    chk("reset_busy20", 32'(busy20), 32'd0);
    repeat (3) @(negedge prog_clk);
    pReset = 1'b1;
    repeat (2) @(negedge prog_clk);

    // Partial last word on the 20-bit chain, then read it back.
    load(18, 3);
    run_pass(1, 3, 20, 1'b0, 1'b0, 25);
    load(21, 3);
    run_pass(1, 3, 20, 1'b0, 1'b0, 25);

    // 48-bit: basic, stalled, start-while-busy.
    load(0, 6);
    run_pass(0, 6, 48, 1'b0, 1'b0, 55);
    load(6, 6);
    run_pass(0, 6, 48, 1'b1, 1'b0, 60);
    load(12, 6);
    run_pass(0, 6, 48, 1'b0, 1'b1, 55);

    // Reset at bit 20 of a pass.
    for (int k = 0; k < 6; k++) wbuf[k] = 8'($urandom_range(0, 255));
    load_chain_exp();
    for (int k = 0; k < 6; k++) exp48_q.push_back(ebuf[k]);
    db = done_cnt[0];
    sb = shift_cnt[0];
    @(negedge prog_clk);
    start48 = 1'b1;
    @(negedge prog_clk);
    start48 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      present_word(0, wbuf[k], 8, ok);
    end
    for (int t = 0; t < 100; t++) begin
      @(posedge prog_clk);
      #2;
      if (shift_cnt[0] - sb >= 20) break;
    end
    chk("abort_at_bit", 32'(shift_cnt[0] - sb), 32'd20);
    in_valid48 = 1'b0;
    pReset = 1'b0;
    #1;
    check_reset_outputs("abort");
    chk("abort_rb_popped", 32'(exp48_q.size()), 32'd4);
    exp48_q.delete();
    hexp48_q.delete();
    repeat (2) @(negedge prog_clk);
    pReset = 1'b1;
    sb = shift_cnt[0];
    repeat (20) @(negedge prog_clk);
    chk("abort_no_done", 32'(done_cnt[0] - db), 32'd0);
    chk("abort_chain_still", 32'(shift_cnt[0] - sb), 32'd0);

    // Full pass after the abort.
    for (int k = 0; k < 6; k++) wbuf[k] = 8'($urandom_range(0, 255));
    load_chain_exp();
    run_pass(0, 6, 48, 1'b0, 1'b0, 55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
